// File: rtl/prim_pipe_pkg.sv
// prim_pipe_pkg
// Shared definitions for the prim_pipe_reg pipeline register slice.
//   pipe_cnt_w(depth) : width of an occupancy counter able to hold 0..depth
//   MaxDepth          : largest supported number of register stages

package prim_pipe_pkg;

    localparam int MaxDepth = 16;

    function automatic int pipe_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prim_pipe_stage.sv
// prim_pipe_stage
// One stage of the pipeline register: a valid flop, a data flop and, when
// PRIM_PIPE_REG_PARITY_EN is defined, a parity flop that travels with the data.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          stage may take the upstream contents this edge
//   flush_i         clear the valid bit, hold data
//   valid_i/data_i  contents offered by the upstream stage (or pipe input)
//   parity_i        parity bit offered upstream (parity build only)
//   valid_o/data_o  registered stage contents
//   valid_next_o    value the valid flop will take at the next edge
//   parity_o        registered parity bit (parity build only)

module prim_pipe_stage
    import prim_pipe_pkg::*;
#(
    parameter int                Width      = 8,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
`ifdef PRIM_PIPE_REG_PARITY_EN
    input  logic             parity_i,
    output logic             parity_o,
`endif
    output logic             valid_o,
    output logic             valid_next_o,
    output logic [Width-1:0] data_o
);

    logic             valid_q;
    logic [Width-1:0] data_q;
    logic             data_en;

    // Flush wins over any load; an empty slot offered from upstream still
    // propagates as a bubble so the downstream slot can be refilled.
    assign valid_next_o = flush_i ? 1'b0 : (load_i ? valid_i : valid_q);

    // Data only moves with a valid item, so bubbles never disturb the payload.
    assign data_en = load_i && valid_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_next_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= ResetValue;
        end else if (data_en) begin
            data_q <= data_i;
        end
    end

`ifdef PRIM_PIPE_REG_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_q <= ^ResetValue;
        end else if (data_en) begin
            parity_q <= parity_i;
        end
    end

    assign parity_o = parity_q;
`endif

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/prim_pipe_reg.sv
// prim_pipe_reg
// Depth-stage, Width-bit flop pipeline with valid/ready handshake, bubble
// collapsing, synchronous flush and a registered occupancy count.
// Optional macro PRIM_PIPE_REG_PARITY_EN adds a per-stage parity flop and
// drives parity_err_o; otherwise parity_err_o is tied low.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   in_valid_i/in_ready_o      upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i    downstream handshake, out_data_o payload
//   flush_i                    discard all contents at the next edge
//   count_o                    number of valid stages (0..Depth)
//   parity_err_o               output parity mismatch (parity build only)

module prim_pipe_reg
    import prim_pipe_pkg::*;
#(
    parameter int               Width      = 8,
    parameter int               Depth      = 2,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [Width-1:0]             in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [Width-1:0]             out_data_o,
    input  logic                         flush_i,
    output logic [pipe_cnt_w(Depth)-1:0] count_o,
    output logic                         parity_err_o
);

    localparam int CntW = pipe_cnt_w(Depth);

    if (Depth < 1 || Depth > MaxDepth) begin : gen_depth_check
        $error("prim_pipe_reg: Depth must be within 1..16");
    end

    logic [Depth-1:0] valid_q;
    logic [Depth-1:0] valid_next;
    logic [Depth-1:0] rdy;
    logic [Width-1:0] data_q [Depth];
`ifdef PRIM_PIPE_REG_PARITY_EN
    logic [Depth-1:0] parity_q;
`endif
    logic [CntW-1:0]  count_d;
    logic [CntW-1:0]  count_q;

    // Ready ripples from the output back to the input: an empty stage always
    // accepts, a full stage accepts only if the stage after it moves on.
    always_comb begin
        rdy = '0;
        rdy[Depth-1] = !valid_q[Depth-1] || out_ready_i;
        for (int k = Depth - 2; k >= 0; k--) begin
            rdy[k] = !valid_q[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < Depth; k++) begin : gen_stage
        logic             prev_valid;
        logic [Width-1:0] prev_data;
`ifdef PRIM_PIPE_REG_PARITY_EN
        logic             prev_parity;
`endif

        if (k == 0) begin : gen_head
            assign prev_valid  = in_valid_i;
            assign prev_data   = in_data_i;
`ifdef PRIM_PIPE_REG_PARITY_EN
            assign prev_parity = ^in_data_i;
`endif
        end else begin : gen_link
            assign prev_valid  = valid_q[k-1];
            assign prev_data   = data_q[k-1];
`ifdef PRIM_PIPE_REG_PARITY_EN
            assign prev_parity = parity_q[k-1];
`endif
        end

        prim_pipe_stage #(
            .Width      (Width),
            .ResetValue (ResetValue)
        ) u_stage (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .load_i       (rdy[k]),
            .flush_i      (flush_i),
            .valid_i      (prev_valid),
            .data_i       (prev_data),
`ifdef PRIM_PIPE_REG_PARITY_EN
            .parity_i     (prev_parity),
            .parity_o     (parity_q[k]),
`endif
            .valid_o      (valid_q[k]),
            .valid_next_o (valid_next[k]),
            .data_o       (data_q[k])
        );
    end

    // Counting the next-state valid bits keeps count_o aligned with the
    // registered valid bits while still coming straight from a flop.
    always_comb begin
        count_d = '0;
        for (int k = 0; k < Depth; k++) begin
            count_d = count_d + CntW'(valid_next[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_ready_o  = rdy[0] && !flush_i;
    assign out_valid_o = valid_q[Depth-1] && !flush_i;
    assign out_data_o  = data_q[Depth-1];
    assign count_o     = count_q;

`ifdef PRIM_PIPE_REG_PARITY_EN
    assign parity_err_o = out_valid_o && ((^out_data_o) != parity_q[Depth-1]);
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_pipe_reg.sv
// tb_prim_pipe_reg
// Directed bench for prim_pipe_reg with two instances sharing clock and reset:
// a Depth=2 pipe for streaming and reset scenarios, and a Depth=3 pipe for
// backpressure, bubble collapsing and flush scenarios.

module tb_prim_pipe_reg;

    logic       clk;
    logic       rst_n;

    logic       in_valid2, in_ready2, out_valid2, out_ready2, flush2, perr2;
    logic [7:0] in_data2, out_data2;
    logic [1:0] count2;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, flush3, perr3;
    logic [7:0] in_data3, out_data3;
    logic [1:0] count3;

    int checks;
    int failures;

    prim_pipe_reg #(.Width(8), .Depth(2), .ResetValue(8'h00)) u_dut2 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid2),
        .in_ready_o   (in_ready2),
        .in_data_i    (in_data2),
        .out_valid_o  (out_valid2),
        .out_ready_i  (out_ready2),
        .out_data_o   (out_data2),
        .flush_i      (flush2),
        .count_o      (count2),
        .parity_err_o (perr2)
    );

    prim_pipe_reg #(.Width(8), .Depth(3), .ResetValue(8'h00)) u_dut3 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid3),
        .in_ready_o   (in_ready3),
        .in_data_i    (in_data3),
        .out_valid_o  (out_valid3),
        .out_ready_i  (out_ready3),
        .out_data_o   (out_data3),
        .flush_i      (flush3),
        .count_o      (count3),
        .parity_err_o (perr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one DUT's inputs and parks the other one idle.
    task automatic applyStimulus(input bit sel3, input logic valid,
                                 input logic [7:0] data, input logic ready,
                                 input logic flush);
        if (sel3) begin
            in_valid3 = valid; in_data3 = data; out_ready3 = ready; flush3 = flush;
            in_valid2 = 1'b0;  in_data2 = 8'h00; out_ready2 = 1'b0; flush2 = 1'b0;
        end else begin
            in_valid2 = valid; in_data2 = data; out_ready2 = ready; flush2 = flush;
            in_valid3 = 1'b0;  in_data3 = 8'h00; out_ready3 = 1'b0; flush3 = 1'b0;
        end
        #1;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #10;

        // Reset state
        checkOutput("rst_out_valid", {31'd0, out_valid2}, 32'd0);
        checkOutput("rst_out_data",  {24'd0, out_data2},  32'h00);
        checkOutput("rst_count",     {30'd0, count2},     32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready2},  32'd1);
        checkOutput("rst_perr",      {31'd0, perr2},      32'd0);
        checkOutput("rst_count3",    {30'd0, count3},     32'd0);
        rst_n = 1'b1;
        waitCycle();

        // Streaming through Depth=2 with out_ready held high
        applyStimulus(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
        waitCycle();
        checkOutput("s1_count_e1", {30'd0, count2},     32'd1);
        checkOutput("s1_valid_e1", {31'd0, out_valid2}, 32'd0);
        applyStimulus(1'b0, 1'b1, 8'h22, 1'b1, 1'b0);
        waitCycle();
        checkOutput("s1_valid_e2", {31'd0, out_valid2}, 32'd1);
        checkOutput("s1_data_e2",  {24'd0, out_data2},  32'h11);
        checkOutput("s1_count_e2", {30'd0, count2},     32'd2);
        applyStimulus(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        waitCycle();
        checkOutput("s1_data_e3",  {24'd0, out_data2},  32'h22);
        checkOutput("s1_count_e3", {30'd0, count2},     32'd2);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        waitCycle();
        checkOutput("s1_data_e4",  {24'd0, out_data2},  32'h33);
        checkOutput("s1_valid_e4", {31'd0, out_valid2}, 32'd1);
        checkOutput("s1_count_e4", {30'd0, count2},     32'd1);
        checkOutput("s1_perr",     {31'd0, perr2},      32'd0);
        waitCycle();
        checkOutput("s1_valid_e5", {31'd0, out_valid2}, 32'd0);
        checkOutput("s1_count_e5", {30'd0, count2},     32'd0);

        // Depth=3 fill under backpressure, then drain in order
        applyStimulus(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0);
        checkOutput("s2_ready_0", {31'd0, in_ready3}, 32'd1);
        waitCycle();
        applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        checkOutput("s2_ready_1", {31'd0, in_ready3}, 32'd1);
        waitCycle();
        applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0);
        checkOutput("s2_ready_2", {31'd0, in_ready3}, 32'd1);
        waitCycle();
        applyStimulus(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0);
        checkOutput("s2_ready_full", {31'd0, in_ready3},  32'd0);
        checkOutput("s2_count_full", {30'd0, count3},     32'd3);
        checkOutput("s2_head",       {24'd0, out_data3},  32'hA0);
        waitCycle();
        checkOutput("s2_hold_data",  {24'd0, out_data3},  32'hA0);
        checkOutput("s2_hold_count", {30'd0, count3},     32'd3);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("s2_drain_ready", {31'd0, in_ready3}, 32'd1);
        waitCycle();
        checkOutput("s2_drain1_data",  {24'd0, out_data3}, 32'hA1);
        checkOutput("s2_drain1_count", {30'd0, count3},    32'd2);
        waitCycle();
        checkOutput("s2_drain2_data",  {24'd0, out_data3}, 32'hA2);
        checkOutput("s2_drain2_valid", {31'd0, out_valid3}, 32'd1);
        checkOutput("s2_drain2_count", {30'd0, count3},    32'd1);
        waitCycle();
        checkOutput("s2_empty_valid", {31'd0, out_valid3}, 32'd0);
        checkOutput("s2_empty_count", {30'd0, count3},     32'd0);

        // Bubble collapsing at Depth=3
        applyStimulus(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        waitCycle();
        checkOutput("s3_count_1", {30'd0, count3},    32'd1);
        applyStimulus(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
        checkOutput("s3_ready_1", {31'd0, in_ready3}, 32'd1);
        waitCycle();
        checkOutput("s3_count_2", {30'd0, count3},    32'd2);
        applyStimulus(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
        checkOutput("s3_ready_2", {31'd0, in_ready3}, 32'd1);
        waitCycle();
        applyStimulus(1'b1, 1'b1, 8'hB3, 1'b0, 1'b0);
        checkOutput("s3_ready_full", {31'd0, in_ready3},  32'd0);
        checkOutput("s3_count_3",    {30'd0, count3},     32'd3);
        checkOutput("s3_head",       {24'd0, out_data3},  32'hB0);
        checkOutput("s3_head_valid", {31'd0, out_valid3}, 32'd1);

        // Flush on a full pipe with both handshakes requested
        applyStimulus(1'b1, 1'b1, 8'hC0, 1'b1, 1'b1);
        checkOutput("s4_flush_in_ready",  {31'd0, in_ready3},  32'd0);
        checkOutput("s4_flush_out_valid", {31'd0, out_valid3}, 32'd0);
        waitCycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("s4_post_valid", {31'd0, out_valid3}, 32'd0);
        checkOutput("s4_post_count", {30'd0, count3},     32'd0);
        checkOutput("s4_post_ready", {31'd0, in_ready3},  32'd1);
        checkOutput("s4_data_held",  {24'd0, out_data3},  32'hB0);

        // Asynchronous reset in the middle of a Depth=2 stream
        applyStimulus(1'b0, 1'b1, 8'h44, 1'b1, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b1, 8'h45, 1'b1, 1'b0);
        waitCycle();
        checkOutput("s5_pre_data", {24'd0, out_data2}, 32'h44);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_valid", {31'd0, out_valid2}, 32'd0);
        checkOutput("s5_rst_data",  {24'd0, out_data2},  32'h00);
        checkOutput("s5_rst_count", {30'd0, count2},     32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h5C, 1'b1, 1'b0);
        checkOutput("s5_ready_after", {31'd0, in_ready2}, 32'd1);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("s5_lat_valid", {31'd0, out_valid2}, 32'd0);
        waitCycle();
        checkOutput("s5_out_valid", {31'd0, out_valid2}, 32'd1);
        checkOutput("s5_out_data",  {24'd0, out_data2},  32'h5C);
        checkOutput("s5_perr",      {31'd0, perr2},      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
